alu_sequencer: RTL

- Initiator side of the 8-bit ALU control interface. Accepts calculator commands (operands plus a calculator opcode) over a valid/ready handshake and drives the ALU's A, B and 4-bit Operation inputs.
- Captures Result, Zero, Carry_out and Overflow from the ALU and returns them as a registered response.
- Adds an iterative 8x8 multiply built from repeated ALU ADD steps, making the ALU usable by the calculator front end without the front end knowing ALU control codes.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/calc_op_decode.sv | 37 +++
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator/ALU definitions: calculator opcodes, ALU control codes
// and the sequencer state encoding. Imported by the sequencer and decoder.
package calc_pkg;

    localparam logic [2:0] CALC_ADD     = 3'd0;
    localparam logic [2:0] CALC_SUB     = 3'd1;
    localparam logic [2:0] CALC_AND     = 3'd2;
    localparam logic [2:0] CALC_OR      = 3'd3;
    localparam logic [2:0] CALC_NOR     = 3'd4;
    localparam logic [2:0] CALC_SLT     = 3'd5;
    localparam logic [2:0] CALC_MUL     = 3'd6;
    localparam logic [2:0] CALC_ILLEGAL = 3'd7;

    // [3] Ainvert, [2] Bnegate/carry-in, [1:0] function select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Calculator command/response handshake bundle.
// master = front end (drives cmd_*, rsp_ready); slave = sequencer.
interface alu_sequencer_if #(
    parameter int W = 8
) ();

    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [2:0]     cmd_op;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic           rsp_zero;
    logic           rsp_carry;
    logic           rsp_overflow;
    logic           rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result,
        input  rsp_zero, rsp_carry, rsp_overflow, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result,
        output rsp_zero, rsp_carry, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/calc_op_decode.sv
// Combinational calculator opcode -> ALU control map.
// Ports: i_op (calc opcode) -> o_alu_op, o_is_mul, o_is_err.
module calc_op_decode
    import calc_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic [2:0] i_op,
    output logic [3:0] o_alu_op,
    output logic       o_is_mul,
    output logic       o_is_err
);

    always_comb begin
        o_alu_op = ALU_AND;
        o_is_mul = 1'b0;
        o_is_err = 1'b0;
        unique case (1'b1)
            (i_op == CALC_ADD): o_alu_op = ALU_ADD;
            (i_op == CALC_SUB): o_alu_op = ALU_SUB;
            (i_op == CALC_AND): o_alu_op = ALU_AND;
            (i_op == CALC_OR):  o_alu_op = ALU_OR;
            (i_op == CALC_NOR): o_alu_op = ALU_NOR;
            (i_op == CALC_SLT): o_alu_op = ALU_SLT;
            (i_op == CALC_MUL): begin
                if (ENABLE_MUL) begin
                    o_alu_op = ALU_ADD;
                    o_is_mul = 1'b1;
                end else begin
                    o_is_err = 1'b1;
                end
            end
            default: o_is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Drives an external W-bit ALU from calculator commands; multiply is done
// as W shift-add iterations through the ALU adder.
// Ports: i_clk, i_reset (sync, active-high), bus (cmd/rsp handshake),
// o_alu_a/o_alu_b/o_alu_op to the ALU, i_alu_* results/flags from the ALU.
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 8,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    alu_sequencer_if.slave bus,
    output logic [W-1:0]  o_alu_a,
    output logic [W-1:0]  o_alu_b,
    output logic [3:0]    o_alu_op,
    input  logic [W-1:0]  i_alu_result,
    input  logic          i_alu_zero,
    input  logic          i_alu_carry,
    input  logic          i_alu_overflow
);

    localparam int CW = $clog2(W) + 1;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [3:0]       r_alu_op;
    logic [2*W-1:0]   r_p;
    logic [CW-1:0]    r_cnt;

    logic [2*W-1:0]   r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_carry;
    logic             r_rsp_overflow;
    logic             r_rsp_err;

    logic [3:0]       w_dec_op;
    logic             w_dec_mul;
    logic             w_dec_err;
    logic             w_accept;
    logic             w_mul_last;
    logic [2*W-1:0]   w_p_next;

    calc_op_decode #(
        .ENABLE_MUL (ENABLE_MUL)
    ) u_dec (
        .i_op     (bus.cmd_op),
        .o_alu_op (w_dec_op),
        .o_is_mul (w_dec_mul),
        .o_is_err (w_dec_err)
    );

    assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_mul_last = (r_cnt == CW'(W - 1));
    // Adder carry becomes the new top bit; product shifts right one place
    assign w_p_next   = {i_alu_carry, i_alu_result, r_p[W-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_dec_err)      w_next = S_DONE;
                    else if (w_dec_mul) w_next = S_MUL;
                    else                w_next = S_EXEC;
                end
            end
            S_EXEC: w_next = S_DONE;
            S_MUL:  if (w_mul_last) w_next = S_DONE;
            S_DONE: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.rsp_valid = (r_state == S_DONE);
        o_alu_a       = '0;
        o_alu_b       = '0;
        o_alu_op      = ALU_AND;
        unique case (r_state)
            S_EXEC: begin
                o_alu_a  = r_a;
                o_alu_b  = r_b;
                o_alu_op = r_alu_op;
            end
            S_MUL: begin
                o_alu_a  = r_p[2*W-1:W];
                o_alu_b  = r_p[0] ? r_a : '0;
                o_alu_op = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a            <= '0;
            r_b            <= '0;
            r_alu_op       <= ALU_AND;
            r_p            <= '0;
            r_cnt          <= '0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a            <= bus.cmd_a;
                        r_b            <= bus.cmd_b;
                        r_alu_op       <= w_dec_op;
                        r_p            <= {{W{1'b0}}, bus.cmd_b};
                        r_cnt          <= '0;
                        r_rsp_result   <= '0;
                        r_rsp_zero     <= 1'b0;
                        r_rsp_carry    <= 1'b0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_err      <= w_dec_err;
                    end
                end
                S_EXEC: begin
                    r_rsp_result   <= {{W{1'b0}}, i_alu_result};
                    r_rsp_zero     <= i_alu_zero;
                    r_rsp_carry    <= i_alu_carry;
                    r_rsp_overflow <= i_alu_overflow;
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_rsp_result   <= w_p_next;
                        r_rsp_zero     <= (w_p_next == '0);
                        r_rsp_carry    <= 1'b0;
                        r_rsp_overflow <= |w_p_next[2*W-1:W];
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_result   <= '0;
                        r_rsp_zero     <= 1'b0;
                        r_rsp_carry    <= 1'b0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.rsp_err      = r_rsp_err;

endmodule
